// File: rtl/dcache_probe_sched_pkg.sv
// Shared types for the data-SRAM probe scheduler.
package dcache_probe_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } probe_state_e;

endpackage

// File: rtl/dcache_probe_rr_arb.sv
// Combinational round-robin arbiter: the lowest request index at or after ptr wins.
module dcache_probe_rr_arb #(
    parameter int NR_REQ = 2,
    parameter int IW     = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
) (
    input  logic [NR_REQ-1:0] req,
    input  logic [IW-1:0]     ptr,
    input  logic              en,
    output logic [NR_REQ-1:0] gnt,
    output logic [IW-1:0]     idx,
    output logic              any
);

    int j;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        if (en) begin
            // Walk from farthest to nearest so the last match is the one nearest ptr.
            for (int i = NR_REQ - 1; i >= 0; i--) begin
                j = int'(ptr) + i;
                if (j >= NR_REQ) j = j - NR_REQ;
                if (req[j]) begin
                    gnt    = '0;
                    gnt[j] = 1'b1;
                    idx    = IW'(j);
                    any    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dcache_probe_sched.sv
// Shares the data-SRAM probe port between requesters: reads one full set per
// SRAM access and returns it with a valid/ready handshake, optionally sweeping.
module dcache_probe_sched
    import dcache_probe_sched_pkg::*;
#(
    parameter int NR_REQ           = 2,
    parameter int DCACHE_SET_ASSOC = 8,
    parameter int DATA_WIDTH       = 64,
    parameter int NUM_WORDS        = 256,
    parameter int READ_LATENCY     = 1,
    parameter int AW               = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                                                  clk_i,
    input  logic                                                  rst_i,
    input  logic [NR_REQ-1:0]                                     req_valid_i,
    output logic [NR_REQ-1:0]                                     req_ready_o,
    input  logic [NR_REQ-1:0][AW-1:0]                             req_addr_i,
    input  logic [NR_REQ-1:0]                                     req_sweep_i,
    output logic [NR_REQ-1:0]                                     rsp_valid_o,
    input  logic [NR_REQ-1:0]                                     rsp_ready_i,
    output logic [AW-1:0]                                         rsp_addr_o,
    output logic [DCACHE_SET_ASSOC-1:0][1:0][DATA_WIDTH-1:0]      rsp_data_o,
    output logic                                                  rsp_last_o,
    output logic                                                  rsp_err_o,
    output logic                                                  sram_req_o,
    input  logic                                                  sram_gnt_i,
    output logic [AW-1:0]                                         sram_addr_o,
    input  logic [DCACHE_SET_ASSOC-1:0][1:0][DATA_WIDTH-1:0]      sram_rdata_i,
    output logic                                                  busy_o
);

    localparam int IW = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
    localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam bit POW2 = ((1 << AW) == NUM_WORDS);
    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_WORDS - 1);

    typedef logic [AW-1:0] addr_t;
    typedef logic [DCACHE_SET_ASSOC-1:0][1:0][DATA_WIDTH-1:0] set_data_t;

    // Only a non-power-of-two set count leaves unreachable address codes.
    function automatic logic out_of_range(input addr_t a);
        return !POW2 && ({1'b0, a} >= (AW + 1)'(NUM_WORDS));
    endfunction

    probe_state_e state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] owner_q, owner_d;
    addr_t         addr_q, addr_d;
    logic          sweep_q, sweep_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    set_data_t     data_q, data_d;

    logic              arb_en;
    logic [NR_REQ-1:0] arb_gnt;
    logic [IW-1:0]     arb_idx;
    logic              arb_any;
    logic              last;

    dcache_probe_rr_arb #(
        .NR_REQ (NR_REQ),
        .IW     (IW)
    ) u_arb (
        .req (req_valid_i),
        .ptr (ptr_q),
        .en  (arb_en),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign last = !sweep_q || (addr_q == LAST_ADDR) || err_q;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        sweep_d     = sweep_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        arb_en      = 1'b0;
        req_ready_o = '0;
        rsp_valid_o = '0;
        rsp_last_o  = 1'b0;
        rsp_err_o   = 1'b0;
        sram_req_o  = 1'b0;
        sram_addr_o = '0;

        unique case (state_q)
            IDLE: begin
                arb_en = 1'b1;
                if (arb_any) begin
                    req_ready_o = arb_gnt;
                    owner_d     = arb_idx;
                    addr_d      = req_addr_i[arb_idx];
                    sweep_d     = req_sweep_i[arb_idx];
                    err_d       = out_of_range(req_addr_i[arb_idx]);
                    if (out_of_range(req_addr_i[arb_idx])) begin
                        data_d  = '0;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                sram_req_o  = 1'b1;
                sram_addr_o = addr_q;
                if (sram_gnt_i) begin
                    cnt_d   = CW'(READ_LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    data_d  = sram_rdata_i;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                rsp_valid_o[owner_q] = 1'b1;
                rsp_last_o           = last;
                rsp_err_o            = err_q;
                if (rsp_ready_i[owner_q]) begin
                    if (last) begin
                        ptr_d   = (int'(owner_q) == NR_REQ - 1) ? '0 : owner_q + IW'(1);
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_q + AW'(1);
                        state_d = ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            addr_q  <= '0;
            sweep_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            sweep_q <= sweep_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    assign rsp_addr_o = addr_q;
    assign rsp_data_o = data_q;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_dcache_probe_sched.sv
// Directed bench for dcache_probe_sched: single read, backpressure, reset mid-request,
// sweep end, round-robin with SRAM stall, and out-of-range request on a 200-set instance.
module tb_dcache_probe_sched;

    localparam int NR = 2;
    localparam int SA = 8;
    localparam int DW = 64;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NR-1:0]              req_valid, req_ready, req_sweep, rsp_valid, rsp_ready;
    logic [NR-1:0][AW-1:0]      req_addr;
    logic [AW-1:0]              rsp_addr, sram_addr;
    logic [SA-1:0][1:0][DW-1:0] rsp_data, sram_rdata;
    logic                       rsp_last, rsp_err, sram_req, sram_gnt, busy;

    logic [NR-1:0]              e_req_valid, e_req_ready, e_req_sweep, e_rsp_valid, e_rsp_ready;
    logic [NR-1:0][AW-1:0]      e_req_addr;
    logic [AW-1:0]              e_rsp_addr, e_sram_addr;
    logic [SA-1:0][1:0][DW-1:0] e_rsp_data, e_sram_rdata;
    logic                       e_rsp_last, e_rsp_err, e_sram_req, e_busy;

    int passed = 0;
    int total  = 0;

    dcache_probe_sched #(
        .NR_REQ(NR), .DCACHE_SET_ASSOC(SA), .DATA_WIDTH(DW), .NUM_WORDS(256), .READ_LATENCY(1)
    ) u_dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .req_sweep_i(req_sweep), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_addr_o(rsp_addr), .rsp_data_o(rsp_data), .rsp_last_o(rsp_last),
        .rsp_err_o(rsp_err), .sram_req_o(sram_req), .sram_gnt_i(sram_gnt),
        .sram_addr_o(sram_addr), .sram_rdata_i(sram_rdata), .busy_o(busy)
    );

    dcache_probe_sched #(
        .NR_REQ(NR), .DCACHE_SET_ASSOC(SA), .DATA_WIDTH(DW), .NUM_WORDS(200), .READ_LATENCY(1)
    ) u_dut_200 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(e_req_valid), .req_ready_o(e_req_ready), .req_addr_i(e_req_addr),
        .req_sweep_i(e_req_sweep), .rsp_valid_o(e_rsp_valid), .rsp_ready_i(e_rsp_ready),
        .rsp_addr_o(e_rsp_addr), .rsp_data_o(e_rsp_data), .rsp_last_o(e_rsp_last),
        .rsp_err_o(e_rsp_err), .sram_req_o(e_sram_req), .sram_gnt_i(1'b1),
        .sram_addr_o(e_sram_addr), .sram_rdata_i(e_sram_rdata), .busy_o(e_busy)
    );

    assign e_sram_rdata = '1;

    function automatic logic [63:0] model_word(input int set, input int way, input int k);
        return {8'hA5, 24'h0, 16'(set), 8'(way), 8'(k)};
    endfunction

    // One-cycle-latency SRAM: address accepted on gnt, data valid the following cycle.
    logic [AW-1:0] rd_addr = '0;
    always @(posedge clk) if (sram_req && sram_gnt) rd_addr <= sram_addr;

    always_comb begin
        sram_rdata = '0;
        for (int w = 0; w < SA; w++)
            for (int k = 0; k < 2; k++)
                sram_rdata[w][k] = model_word(int'(rd_addr), w, k);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_set(input string tag, input int set);
        for (int w = 0; w < SA; w++)
            for (int k = 0; k < 2; k++)
                check(tag, rsp_data[w][k], model_word(set, w, k));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid !== '0) return;
            tick();
        end
        check("rsp_timeout", 64'(rsp_valid != '0), 64'(1));
    endtask

    task automatic wait_gnt();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready !== '0) return;
            tick();
        end
        check("gnt_timeout", 64'(req_ready != '0), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR-1:0] exp_own;
        req_valid = '0; req_sweep = '0; req_addr = '0; rsp_ready = '0; sram_gnt = 1'b1;
        e_req_valid = '0; e_req_sweep = '0; e_req_addr = '0; e_rsp_ready = '0;

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_sram_req", 64'(sram_req), 64'(0));
        check("rst_rsp_data", 64'(|rsp_data), 64'(0));

        // Single read of set 5, then hold the response with only the non-owner ready.
        tick();
        req_valid = 2'b01; req_addr[0] = 8'd5; rsp_ready = 2'b10;
        @(negedge clk);
        check("single_ready", 64'(req_ready), 64'(2'b01));
        tick();
        req_valid = '0; req_addr[0] = '0;
        @(negedge clk);
        check("single_sram_req", 64'(sram_req), 64'(1));
        check("single_sram_addr", 64'(sram_addr), 64'(5));
        tick();
        @(negedge clk);
        check("single_wait_no_rsp", 64'(rsp_valid), 64'(0));
        tick();
        @(negedge clk);
        check("single_rsp_valid", 64'(rsp_valid), 64'(2'b01));
        check("single_rsp_addr", 64'(rsp_addr), 64'(5));
        check("single_last", 64'(rsp_last), 64'(1));
        check("single_err", 64'(rsp_err), 64'(0));
        check_set("single_data", 5);
        repeat (10) begin
            tick();
            @(negedge clk);
            check("bp_valid", 64'(rsp_valid), 64'(2'b01));
            check("bp_no_sram", 64'(sram_req), 64'(0));
        end
        check("bp_addr", 64'(rsp_addr), 64'(5));
        check_set("bp_data", 5);
        tick();
        rsp_ready = 2'b11;
        @(negedge clk);
        check("bp_release_valid", 64'(rsp_valid), 64'(2'b01));
        tick();
        @(negedge clk);
        check("bp_idle_busy", 64'(busy), 64'(0));
        check("bp_idle_valid", 64'(rsp_valid), 64'(0));

        // Requester 1 sweep from 100, reset while waiting on the SRAM read.
        tick();
        req_valid = 2'b10; req_addr[1] = 8'd100; req_sweep = 2'b10;
        @(negedge clk);
        check("rstmid_ready", 64'(req_ready), 64'(2'b10));
        tick();
        req_valid = '0; req_sweep = '0;
        @(negedge clk);
        check("rstmid_issue", 64'(sram_req), 64'(1));
        tick();
        @(negedge clk);
        check("rstmid_wait_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_busy", 64'(busy), 64'(0));
        check("rstmid_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rstmid_sram_req", 64'(sram_req), 64'(0));
        check("rstmid_rsp_data", 64'(|rsp_data), 64'(0));
        check("rstmid_rsp_addr", 64'(rsp_addr), 64'(0));
        tick();
        @(negedge clk);
        check("rstmid_no_rsp", 64'(rsp_valid), 64'(0));

        // Both valid after reset: pointer back at 0, so requester 0 wins.
        tick();
        req_valid = 2'b11; req_addr[0] = 8'd7; req_addr[1] = 8'd9;
        @(negedge clk);
        check("postrst_grant", 64'(req_ready), 64'(2'b01));
        tick();
        req_valid = '0;
        wait_rsp();
        check("postrst_valid", 64'(rsp_valid), 64'(2'b01));
        check("postrst_addr", 64'(rsp_addr), 64'(7));
        check("postrst_last", 64'(rsp_last), 64'(1));
        check_set("postrst_data", 7);
        tick();

        // Sweep 252..255 for requester 1; must stop at the last set.
        req_valid = 2'b10; req_addr[1] = 8'd252; req_sweep = 2'b10;
        @(negedge clk);
        check("sweep_grant", 64'(req_ready), 64'(2'b10));
        tick();
        req_valid = '0; req_sweep = '0;
        for (int k = 0; k < 4; k++) begin
            wait_rsp();
            check("sweep_valid", 64'(rsp_valid), 64'(2'b10));
            check("sweep_addr", 64'(rsp_addr), 64'(252 + k));
            check("sweep_last", 64'(rsp_last), 64'(k == 3));
            check("sweep_err", 64'(rsp_err), 64'(0));
            check_set("sweep_data", 252 + k);
            tick();
        end
        @(negedge clk);
        check("sweep_done_busy", 64'(busy), 64'(0));
        check("sweep_done_valid", 64'(rsp_valid), 64'(0));
        check("sweep_done_sram", 64'(sram_req), 64'(0));

        // Round-robin with both requesters always valid; SRAM stalls on the third read.
        tick();
        req_valid = 2'b11; req_addr[0] = 8'd10; req_addr[1] = 8'd20;
        for (int r = 0; r < 4; r++) begin
            exp_own = (r % 2 == 0) ? 2'b01 : 2'b10;
            wait_gnt();
            check("rr_grant", 64'(req_ready), 64'(exp_own));
            tick();
            if (r == 2) begin
                sram_gnt = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    check("stall_sram_req", 64'(sram_req), 64'(1));
                    check("stall_sram_addr", 64'(sram_addr), 64'(10));
                    tick();
                end
                sram_gnt = 1'b1;
            end
            wait_rsp();
            check("rr_rsp_valid", 64'(rsp_valid), 64'(exp_own));
            check("rr_rsp_addr", 64'(rsp_addr), 64'((r % 2 == 0) ? 10 : 20));
            check_set("rr_data", (r % 2 == 0) ? 10 : 20);
            tick();
        end
        req_valid = '0;

        // Out-of-range set on the 200-set instance.
        e_req_valid = 2'b01; e_req_addr[0] = 8'd210; e_req_sweep = 2'b01; e_rsp_ready = 2'b01;
        @(negedge clk);
        check("err_ready", 64'(e_req_ready), 64'(2'b01));
        tick();
        e_req_valid = '0; e_req_sweep = '0;
        @(negedge clk);
        check("err_rsp_valid", 64'(e_rsp_valid), 64'(2'b01));
        check("err_flag", 64'(e_rsp_err), 64'(1));
        check("err_last", 64'(e_rsp_last), 64'(1));
        check("err_data_zero", 64'(|e_rsp_data), 64'(0));
        check("err_no_sram", 64'(e_sram_req), 64'(0));
        check("err_rsp_addr", 64'(e_rsp_addr), 64'(210));
        tick();
        @(negedge clk);
        check("err_idle_busy", 64'(e_busy), 64'(0));
        check("err_idle_valid", 64'(e_rsp_valid), 64'(0));
        check("err_idle_sram", 64'(e_sram_req), 64'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
